// File: rtl/mcu.sv
// rtl/mcu.sv - memory control unit arbitrating the byte-wide unified RAM between IF and MEM
// MEM has priority and its multi-byte transfers run atomically; IF is stalled while MEM holds the port.
module mcu (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [7:0]  if_data_o,
    output logic        if_stall_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_stall_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
);

    typedef enum logic [1:0] {S_IDLE, S_MRD, S_MTAIL, S_MWR} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_last;
    logic [1:0]  r_cnt;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;
    logic        r_done;

    logic        w_grant;
    logic [1:0]  w_req_last;
    logic [1:0]  w_cnt_m1;
    logic [31:0] w_addr_cnt;
    logic [7:0]  w_wbyte;
    logic [31:0] w_asm_mrd;
    logic [31:0] w_asm_final;
    logic        w_unused;

    // IF always drives the port address when idle, so its request line carries no extra information
    assign w_unused    = if_req_i;

    assign w_grant     = (r_state == S_IDLE) && mem_req_i && !r_done && !rst;
    assign w_req_last  = (mem_len_i == 2'b00) ? 2'd0 : (mem_len_i == 2'b01) ? 2'd1 : 2'd3;
    assign w_cnt_m1    = r_cnt - 2'd1;
    assign w_addr_cnt  = r_addr + {30'd0, r_cnt};
    assign w_wbyte     = r_wdata[{r_cnt, 3'b000} +: 8];
    // Each read byte arrives one cycle after its address, hence the cnt-1 lane in MRD
    assign w_asm_mrd   = r_asm | ({24'd0, ram_din_i} << {w_cnt_m1, 3'b000});
    assign w_asm_final = r_asm | ({24'd0, ram_din_i} << {r_last, 3'b000});

    assign if_data_o   = ram_din_i;
    assign mem_rdata_o = r_rdata;
    assign mem_done_o  = r_done;
    assign mem_stall_o = mem_req_i && !r_done && !rst;

    always_comb begin
        ram_addr_o = 32'd0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'd0;
        if_stall_o = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        ram_addr_o = mem_addr_i;
                        ram_wr_o   = mem_we_i;
                        ram_dout_o = mem_wdata_i[7:0];
                        if_stall_o = 1'b1;
                    end else begin
                        ram_addr_o = if_addr_i;
                    end
                end
                S_MRD: begin
                    ram_addr_o = w_addr_cnt;
                    if_stall_o = 1'b1;
                end
                S_MTAIL: begin
                    ram_addr_o = r_addr;
                    if_stall_o = 1'b1;
                end
                S_MWR: begin
                    ram_addr_o = w_addr_cnt;
                    ram_wr_o   = 1'b1;
                    ram_dout_o = w_wbyte;
                    if_stall_o = 1'b1;
                end
                default: begin
                    ram_addr_o = if_addr_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_last  <= 2'd0;
            r_cnt   <= 2'd0;
            r_asm   <= 32'd0;
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_addr  <= mem_addr_i;
                        r_wdata <= mem_wdata_i;
                        r_last  <= w_req_last;
                        r_cnt   <= 2'd1;
                        r_asm   <= 32'd0;
                        if (mem_we_i) begin
                            if (w_req_last == 2'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_MWR;
                            end
                        end else begin
                            r_state <= (w_req_last == 2'd0) ? S_MTAIL : S_MRD;
                        end
                    end
                end
                S_MRD: begin
                    r_asm <= w_asm_mrd;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == r_last) begin
                        r_state <= S_MTAIL;
                    end
                end
                S_MTAIL: begin
                    r_rdata <= w_asm_final;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_MWR: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == r_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
